// File: rtl/mult_16_pkg.sv
// Shared constants for the 16-bit shift-add multiplier datapath.
package mult_16_pkg;

  localparam int WIDTH     = 16;
  localparam int CNT_W     = 5;
  localparam int ACC_W     = 2 * WIDTH + 1;
  localparam int CNT_DONE  = WIDTH + 1;
  localparam int CNT_START = 0;

endpackage

// File: rtl/mult_add_16.sv
// Combinational adder for the multiplier: zero-extends both operands so the
// carry out is kept as the top bit of the sum.
module mult_add_16
  import mult_16_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mult_dp_16.sv
// Datapath of the 16-bit shift-add multiplier: multiplicand register,
// accumulator/shift register and iteration counter. Optional ovf output is
// enabled by defining MULT_DP_OVF_EN.
module mult_dp_16
  import mult_16_pkg::*;
#(
  parameter int WIDTH = mult_16_pkg::WIDTH,
  parameter int CNT_W = mult_16_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   multiplicand_in,
  input  logic [WIDTH-1:0]   multiplier_in,
  input  logic               wr_shift_reg,
  input  logic               sl_shift,
  input  logic               wr_counter,
  input  logic               rt_shift_reg,
  input  logic               rt_counter,
  input  logic               rt_multiplicand,
  output logic [CNT_W-1:0]   counter,
`ifdef MULT_DP_OVF_EN
  output logic               ovf,
`endif
  output logic               ls_bit,
  output logic [2*WIDTH-1:0] product
);

  localparam int AW = 2 * WIDTH + 1;

  logic [AW-1:0]    acc_reg;
  logic [AW-1:0]    acc_next;
  logic [WIDTH-1:0] mcand_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [WIDTH:0]   sum;

  mult_add_16 #(
    .W(WIDTH)
  ) u_add (
    .a  (acc_reg[2*WIDTH-1:WIDTH]),
    .b  (mcand_reg),
    .sum(sum)
  );

  // Add and shift share one edge: the carry in sum[WIDTH] lands in hi[MSB].
  always_comb begin
    acc_next = acc_reg;
    if (rt_shift_reg) begin
      acc_next = {{(WIDTH+1){1'b0}}, multiplier_in};
    end else if (wr_shift_reg && sl_shift) begin
      acc_next = {1'b0, sum, acc_reg[WIDTH-1:1]};
    end else if (sl_shift) begin
      acc_next = {1'b0, acc_reg[AW-1:1]};
    end else if (wr_shift_reg) begin
      acc_next = {sum, acc_reg[WIDTH-1:0]};
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (rt_counter) begin
      cnt_next = '0;
    end else if (wr_counter) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg   <= '0;
      mcand_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_next;
      if (rt_multiplicand) begin
        mcand_reg <= multiplicand_in;
      end
    end
  end

`ifdef MULT_DP_OVF_EN
  logic ovf_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_reg <= 1'b0;
    end else if (rt_shift_reg) begin
      ovf_reg <= 1'b0;
    end else begin
      ovf_reg <= |acc_next[2*WIDTH-1:WIDTH];
    end
  end

  assign ovf = ovf_reg;
`endif

  assign counter = cnt_reg;
  assign ls_bit  = acc_reg[0];
  assign product = acc_reg[2*WIDTH-1:0];

endmodule

// File: tb/tb_mult_dp_16.sv
// Directed bench for mult_dp_16: table of full multiplications plus
// hand-written sequences for reset, priority and counter wrap corners.
module tb_mult_dp_16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] multiplicand_in;
  logic [15:0] multiplier_in;
  logic        wr_shift_reg;
  logic        sl_shift;
  logic        wr_counter;
  logic        rt_shift_reg;
  logic        rt_counter;
  logic        rt_multiplicand;
  logic [4:0]  counter;
  logic        ls_bit;
  logic [31:0] product;
`ifdef MULT_DP_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mult_dp_16 dut (
    .clk            (clk),
    .reset          (reset),
    .multiplicand_in(multiplicand_in),
    .multiplier_in  (multiplier_in),
    .wr_shift_reg   (wr_shift_reg),
    .sl_shift       (sl_shift),
    .wr_counter     (wr_counter),
    .rt_shift_reg   (rt_shift_reg),
    .rt_counter     (rt_counter),
    .rt_multiplicand(rt_multiplicand),
    .counter        (counter),
`ifdef MULT_DP_OVF_EN
    .ovf            (ovf),
`endif
    .ls_bit         (ls_bit),
    .product        (product)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] prod;
    logic        ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_shift_reg    = 1'b0;
    sl_shift        = 1'b0;
    wr_counter      = 1'b0;
    rt_shift_reg    = 1'b0;
    rt_counter      = 1'b0;
    rt_multiplicand = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] a, input logic [15:0] b);
    idle();
    rt_counter = 1'b1;
    step();
    idle();
    multiplicand_in = a;
    multiplier_in   = b;
    rt_shift_reg    = 1'b1;
    rt_multiplicand = 1'b1;
    wr_counter      = 1'b1;
    step();
    idle();
    multiplicand_in = 16'hDEAD;
    multiplier_in   = 16'hBEEF;
  endtask

  task automatic iterate(input int n, output logic saw_ls);
    saw_ls = 1'b0;
    for (int k = 0; k < n; k++) begin
      saw_ls       = saw_ls | ls_bit;
      wr_shift_reg = ls_bit;
      sl_shift     = 1'b1;
      wr_counter   = 1'b1;
      step();
    end
    idle();
  endtask

  initial begin
    logic saw;
    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F, 1'b0};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1};
    vecs[2] = '{16'h1234, 16'h0000, 32'h00000000, 1'b0};
    vecs[3] = '{16'h0001, 16'hFFFF, 32'h0000FFFF, 1'b0};
    vecs[4] = '{16'h8000, 16'h0002, 32'h00010000, 1'b1};
    vecs[5] = '{16'h00FF, 16'h0101, 32'h0000FFFF, 1'b0};
    vecs[6] = '{16'hABCD, 16'h1234, 32'h0C374FA4, 1'b1};

    multiplicand_in = '0;
    multiplier_in   = '0;
    idle();
    reset = 1'b1;
    #12;
    check("reset_counter", 32'(counter), 32'd0);
    check("reset_product", product, 32'h0);
    check("reset_ls_bit", 32'(ls_bit), 32'd0);
    reset = 1'b0;
    step();

    foreach (vecs[i]) begin
      start(vecs[i].a, vecs[i].b);
      check("load_counter", 32'(counter), 32'd1);
      iterate(16, saw);
      check("done_counter", 32'(counter), 32'd17);
      check("product", product, vecs[i].prod);
      if (vecs[i].b == 16'h0) check("ls_bit_zero", 32'(saw), 32'd0);
`ifdef MULT_DP_OVF_EN
      check("ovf", 32'(ovf), 32'(vecs[i].ovf));
`endif
      step();
      step();
      check("hold_product", product, vecs[i].prod);
      check("hold_counter", 32'(counter), 32'd17);
      $display("vec %0d: 0x%04h * 0x%04h -> 0x%08h", i, vecs[i].a, vecs[i].b, product);
    end

    // Asynchronous reset in the middle of an operation.
    start(16'h00FF, 16'h00FF);
    iterate(7, saw);
    check("pre_reset_counter", 32'(counter), 32'd8);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_counter", 32'(counter), 32'd0);
    check("async_rst_product", product, 32'h0);
    check("async_rst_ls_bit", 32'(ls_bit), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    $display("async reset: counter=%0d product=0x%08h", counter, product);

    // Load overrides add and shift in the same cycle.
    multiplicand_in = 16'h0F0F;
    rt_multiplicand = 1'b1;
    multiplier_in   = 16'h0001;
    rt_shift_reg    = 1'b1;
    step();
    idle();
    multiplier_in = 16'h00AA;
    rt_shift_reg  = 1'b1;
    wr_shift_reg  = 1'b1;
    sl_shift      = 1'b1;
    step();
    idle();
    check("load_priority_product", product, 32'h000000AA);
    check("load_priority_ls_bit", 32'(ls_bit), 32'd0);
    $display("load priority: product=0x%08h ls_bit=%0b", product, ls_bit);

    // Add only, then shift only, from a known accumulator.
    wr_shift_reg = 1'b1;
    step();
    idle();
    check("add_only", product, 32'h0F0F00AA);
    sl_shift = 1'b1;
    step();
    idle();
    check("shift_only", product, 32'h07878055);
    check("shift_ls_bit", 32'(ls_bit), 32'd1);

    // Clear wins over increment.
    wr_counter = 1'b1;
    step();
    step();
    rt_counter = 1'b1;
    step();
    idle();
    check("clr_priority", 32'(counter), 32'd0);
    $display("clear priority: counter=%0d", counter);

    // Counter wraps from 31 to 0.
    wr_counter = 1'b1;
    for (int k = 0; k < 31; k++) step();
    check("count_31", 32'(counter), 32'd31);
    step();
    idle();
    check("count_wrap", 32'(counter), 32'd0);
    $display("wrap: counter=%0d", counter);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

endmodule
